// File: rtl/ms_display_pkg.sv
// ms_display shared types and constants.
// State enum, digit geometry and seven-segment table.
package ms_display_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  localparam int NDIG  = 5;
  localparam int BIN_W = 15;
  localparam int BCD_W = 4 * NDIG;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  function automatic logic [6:0] seg7(
    input logic [3:0] n
  );
    logic [6:0] s;
    s = SEG_BLANK;
    case (n)
      4'd0: s = 7'h40;
      4'd1: s = 7'h79;
      4'd2: s = 7'h24;
      4'd3: s = 7'h30;
      4'd4: s = 7'h19;
      4'd5: s = 7'h12;
      4'd6: s = 7'h02;
      4'd7: s = 7'h78;
      4'd8: s = 7'h00;
      4'd9: s = 7'h10;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/ms_display_if.sv
// ms_display bus: load strobe, count,
// converter status and display drive.
interface ms_display_if;
  import ms_display_pkg::*;

  logic [BIN_W-1:0] i_timer_ms;
  logic             i_load;
  logic             o_busy;
  logic             o_valid;
  logic [BCD_W-1:0] o_bcd;
  logic [NDIG-1:0]  o_an;
  logic [7:0]       o_seg;

  modport master (
    output i_timer_ms,
    output i_load,
    input  o_busy,
    input  o_valid,
    input  o_bcd,
    input  o_an,
    input  o_seg
  );

  modport slave (
    input  i_timer_ms,
    input  i_load,
    output o_busy,
    output o_valid,
    output o_bcd,
    output o_an,
    output o_seg
  );

endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary to BCD.
// One bit per cycle, result held until next load.
module bin2bcd_seq
  import ms_display_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [BIN_W-1:0] i_bin,
  output logic             o_busy,
  output logic             o_valid,
  output logic [BCD_W-1:0] o_bcd
);

  state_t           state;
  logic [BIN_W-1:0] bin;
  logic [BCD_W-1:0] scr;
  logic [BCD_W-1:0] adj;
  logic [3:0]       iter;

  // add 3 to every scratch nibble >= 5
  always_comb begin
    adj = scr;
    for (int k = 0; k < NDIG; k++) begin
      if (scr[4*k +: 4] >= 4'd5)
        adj[4*k +: 4] = scr[4*k +: 4] + 4'd3;
    end
  end

  // converter FSM with registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      bin     <= '0;
      scr     <= '0;
      iter    <= '0;
      o_busy  <= 1'b0;
      o_valid <= 1'b0;
      o_bcd   <= '0;
    end else begin
      o_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (i_load) begin
            bin    <= i_bin;
            scr    <= '0;
            iter   <= '0;
            o_busy <= 1'b1;
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          {scr, bin} <= {adj, bin} << 1;
          iter       <= iter + 4'd1;
          if (iter == 4'(BIN_W - 1))
            state <= DONE;
        end
        DONE: begin
          o_bcd   <= scr;
          o_valid <= 1'b1;
          o_busy  <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/ms_display.sv
// ms_display: BCD conversion + 5-digit scan.
// Optional LZ_BLANK_EN blanks leading zeros.
module ms_display
  import ms_display_pkg::*;
#(
  parameter logic [16:0] SCAN_CNTM = 17'd124999
) (
  input  logic        clk,
  input  logic        rst_n,
  ms_display_if.slave bus
);

  logic [16:0]     pre;
  logic [2:0]      idx;
  logic [3:0]      nib;
  logic            blank;
  logic [NDIG-1:0] an_nxt;
  logic [BCD_W-1:0] bcd;

  assign bcd = bus.o_bcd;

  bin2bcd_seq u_conv (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (bus.i_load),
    .i_bin   (bus.i_timer_ms),
    .o_busy  (bus.o_busy),
    .o_valid (bus.o_valid),
    .o_bcd   (bus.o_bcd)
  );

  // free-running prescaler and digit index
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pre <= '0;
      idx <= '0;
    end else if (pre == SCAN_CNTM) begin
      pre <= '0;
      if (idx == 3'(NDIG - 1))
        idx <= '0;
      else
        idx <= idx + 3'd1;
    end else begin
      pre <= pre + 17'd1;
    end
  end

  // select current nibble and blanking
  always_comb begin
    nib   = bcd[3:0];
    blank = 1'b0;
    unique case (1'b1)
      (idx == 3'd1): nib = bcd[7:4];
      (idx == 3'd2): nib = bcd[11:8];
      (idx == 3'd3): nib = bcd[15:12];
      (idx == 3'd4): nib = bcd[19:16];
      default:       nib = bcd[3:0];
    endcase
`ifdef LZ_BLANK_EN
    unique case (1'b1)
      (idx == 3'd1): blank = (bcd[19:4] == '0);
      (idx == 3'd2): blank = (bcd[19:8] == '0);
      (idx == 3'd3): blank = (bcd[19:12] == '0);
      (idx == 3'd4): blank = (bcd[19:16] == '0);
      default:       blank = 1'b0;
    endcase
`endif
    an_nxt = ~(NDIG'(1) << idx);
  end

  // registered anode and segment drive
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.o_an  <= 5'b11110;
      bus.o_seg <= 8'hC0;
    end else begin
      bus.o_an  <= an_nxt;
      bus.o_seg <= blank ? 8'hFF
                         : {1'b1, seg7(nib)};
    end
  end

endmodule

// File: tb/tb_ms_display.sv
// tb_ms_display: random conversions vs
// arithmetic model, scan and reset checks.
module tb_ms_display;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;

  always #5 clk = ~clk;

  ms_display_if bus ();

  ms_display #(.SCAN_CNTM(17'd3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always @(posedge clk) begin
    if (!rst_n) cyc = 0;
    else        cyc = cyc + 1;
  end

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, obs, exp);
    end
  endtask

  function automatic logic [19:0] to_bcd(int v);
    logic [19:0] r;
    r = '0;
    for (int k = 0; k < 5; k++)
      r = r | (20'((v / (10 ** k)) % 10) << (4 * k));
    return r;
  endfunction

  function automatic logic [7:0] seg_ref(int v, int k);
    logic [6:0] tbl [10];
    int d;
    tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
            7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    d = (v / (10 ** k)) % 10;
`ifdef LZ_BLANK_EN
    if (k > 0 && (v / (10 ** k)) == 0)
      return 8'hFF;
`endif
    return {1'b1, tbl[d]};
  endfunction

  task automatic conv(input int v, input bit extra);
    @(negedge clk);
    bus.i_timer_ms = 15'(v);
    bus.i_load = 1'b1;
    @(negedge clk);
    bus.i_load = 1'b0;
    for (int k = 0; k < 16; k++) begin
      chk("busy", 32'(bus.o_busy), 1);
      chk("valid_early", 32'(bus.o_valid), 0);
      if (extra && (k == 4 || k == 15)) begin
        bus.i_timer_ms = 15'($urandom_range(0, 32767));
        bus.i_load = 1'b1;
      end else begin
        bus.i_load = 1'b0;
      end
      @(negedge clk);
    end
    bus.i_load = 1'b0;
    chk("valid", 32'(bus.o_valid), 1);
    chk("busy_end", 32'(bus.o_busy), 0);
    chk("bcd", 32'(bus.o_bcd), 32'(to_bcd(v)));
    if (extra) begin
      repeat (20) begin
        @(negedge clk);
        chk("valid_dup", 32'(bus.o_valid), 0);
      end
      chk("bcd_hold", 32'(bus.o_bcd), 32'(to_bcd(v)));
    end else begin
      @(negedge clk);
      chk("valid_pulse", 32'(bus.o_valid), 0);
    end
  endtask

  initial begin
    int e;
    int ix;
    logic [4:0] an_exp;
    bus.i_load = 1'b0;
    bus.i_timer_ms = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_bcd", 32'(bus.o_bcd), 0);
    chk("rst_an", 32'(bus.o_an), 32'h1E);
    chk("rst_seg", 32'(bus.o_seg), 32'hC0);
    chk("rst_busy", 32'(bus.o_busy), 0);
    chk("rst_valid", 32'(bus.o_valid), 0);
    rst_n = 1'b1;

    conv(1234, 1'b0);
    conv(32767, 1'b0);
    conv(0, 1'b0);
    repeat (10) conv(int'($urandom_range(0, 32767)), 1'b0);
    conv(1234, 1'b1);

    // reset in the middle of a conversion
    @(negedge clk);
    bus.i_timer_ms = 15'd4321;
    bus.i_load = 1'b1;
    @(negedge clk);
    bus.i_load = 1'b0;
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_valid", 32'(bus.o_valid), 0);
    chk("mid_busy", 32'(bus.o_busy), 0);
    chk("mid_bcd", 32'(bus.o_bcd), 0);
    rst_n = 1'b1;
    repeat (20) begin
      @(negedge clk);
      chk("mid_novalid", 32'(bus.o_valid), 0);
    end
    conv(int'($urandom_range(0, 32767)), 1'b0);

    // scan check from a fresh reset
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    conv(905, 1'b0);
    repeat (45) begin
      @(negedge clk);
      e = cyc;
      ix = (e == 0) ? 0 : ((e - 1) / 4) % 5;
      an_exp = ~(5'(1) << ix);
      chk("scan_an", 32'(bus.o_an), 32'(an_exp));
      chk("scan_seg", 32'(bus.o_seg),
          32'(seg_ref(905, ix)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
